// File: rtl/exe_mem_issue.sv
// rtl/exe_mem_issue.sv - execute-stage address generation, ALE check and data-bus request issue
module exe_mem_issue (
    input  logic        clk,
    input  logic        resetn,
    output logic        es_allowin,
    input  logic        ds2es_valid,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_base,
    input  logic [31:0] ds_offset,
    input  logic [31:0] ds_st_data,
    input  logic [7:0]  ds_mem_op,
    input  logic        ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic [6:0]  ds_ex,
    input  logic        ms_allowin,
    output logic        es2ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic [4:0]  es_ld_op,
    output logic        es_wait_data,
    output logic [7:0]  es_ex_zip,
    output logic        es_fwd_load,
    output logic        es_fwd_we,
    output logic [4:0]  es_fwd_waddr,
    output logic        es_ex,
    input  logic        ms_ex,
    input  logic        wb_ex,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok
);
    logic        es_valid;
    logic        req_sent;
    logic [31:0] pc_r, base_r, offset_r, st_data_r;
    logic [7:0]  mem_op_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [6:0]  ex_r;

    logic        ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w;
    logic [31:0] addr;
    logic        is_mem, ale, need_req, req_hs, es_ready_go;

    assign {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w} = mem_op_r;

    assign addr     = base_r + offset_r;
    assign is_mem   = |mem_op_r;
    assign ale      = ((ld_h | ld_hu | st_h) & addr[0]) | ((ld_w | st_w) & (addr[1:0] != 2'b00));
    assign es_ex    = es_valid & ((|ex_r) | ale);
    assign need_req = is_mem & ~es_ex & ~ms_ex;

    // Request is suppressed by any downstream exception or flush so no side effect escapes.
    assign data_sram_req = es_valid & is_mem & ~es_ex & ~ms_ex & ~wb_ex & ~req_sent;
    assign req_hs        = data_sram_req & data_sram_addr_ok;

    assign es_ready_go = ~need_req | req_sent | req_hs;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;

    assign es_pc        = pc_r;
    assign es_result    = is_mem ? addr : base_r;
    assign es_ld_op     = {ld_b, ld_bu, ld_h, ld_hu, ld_w};
    assign es_wait_data = req_sent | req_hs;
    assign es_ex_zip    = {ex_r, ale};
    assign es_fwd_load  = es_valid & (|es_ld_op);
    assign es_fwd_we    = es_valid & rf_we_r;
    assign es_fwd_waddr = rf_waddr_r;

    assign data_sram_wr   = st_b | st_h | st_w;
    assign data_sram_size = {ld_w | st_w, ld_h | ld_hu | st_h};
    assign data_sram_addr = addr;

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = st_data_r;
        if (st_b) begin
            data_sram_wstrb = 4'b0001 << addr[1:0];
            data_sram_wdata = {4{st_data_r[7:0]}};
        end else if (st_h) begin
            data_sram_wstrb = 4'b0011 << {addr[1], 1'b0};
            data_sram_wdata = {2{st_data_r[15:0]}};
        end else if (st_w) begin
            data_sram_wstrb = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (wb_ex) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds2es_valid;
        end
    end

    // Remembers an accepted request while the instruction is stalled by the memory stage.
    always_ff @(posedge clk) begin
        if (!resetn || wb_ex) begin
            req_sent <= 1'b0;
        end else if (es2ms_valid && ms_allowin) begin
            req_sent <= 1'b0;
        end else if (req_hs) begin
            req_sent <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_r       <= 32'h0;
            base_r     <= 32'h0;
            offset_r   <= 32'h0;
            st_data_r  <= 32'h0;
            mem_op_r   <= 8'h0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'h0;
            ex_r       <= 7'h0;
        end else if (ds2es_valid && es_allowin) begin
            pc_r       <= ds_pc;
            base_r     <= ds_base;
            offset_r   <= ds_offset;
            st_data_r  <= ds_st_data;
            mem_op_r   <= ds_mem_op;
            rf_we_r    <= ds_rf_we;
            rf_waddr_r <= ds_rf_waddr;
            ex_r       <= ds_ex;
        end
    end
endmodule

// File: tb/tb_exe_mem_issue.sv
// tb/tb_exe_mem_issue.sv - directed self-checking bench for exe_mem_issue
module tb_exe_mem_issue;
    logic        clk = 1'b0;
    logic        resetn;
    logic        es_allowin;
    logic        ds2es_valid;
    logic [31:0] ds_pc, ds_base, ds_offset, ds_st_data;
    logic [7:0]  ds_mem_op;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic [6:0]  ds_ex;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic [31:0] es_pc, es_result;
    logic [4:0]  es_ld_op;
    logic        es_wait_data;
    logic [7:0]  es_ex_zip;
    logic        es_fwd_load, es_fwd_we;
    logic [4:0]  es_fwd_waddr;
    logic        es_ex;
    logic        ms_ex, wb_ex;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok;

    int checks = 0;
    int errors = 0;
    int req_cycles;
    int handshakes;

    localparam logic [7:0] OP_NONE = 8'b0000_0000;
    localparam logic [7:0] OP_LD_H = 8'b0010_0000;
    localparam logic [7:0] OP_LD_W = 8'b0000_1000;
    localparam logic [7:0] OP_ST_B = 8'b0000_0100;
    localparam logic [7:0] OP_ST_H = 8'b0000_0010;
    localparam logic [7:0] OP_ST_W = 8'b0000_0001;

    exe_mem_issue dut (
        .clk(clk), .resetn(resetn), .es_allowin(es_allowin), .ds2es_valid(ds2es_valid),
        .ds_pc(ds_pc), .ds_base(ds_base), .ds_offset(ds_offset), .ds_st_data(ds_st_data),
        .ds_mem_op(ds_mem_op), .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr), .ds_ex(ds_ex),
        .ms_allowin(ms_allowin), .es2ms_valid(es2ms_valid), .es_pc(es_pc), .es_result(es_result),
        .es_ld_op(es_ld_op), .es_wait_data(es_wait_data), .es_ex_zip(es_ex_zip),
        .es_fwd_load(es_fwd_load), .es_fwd_we(es_fwd_we), .es_fwd_waddr(es_fwd_waddr),
        .es_ex(es_ex), .ms_ex(ms_ex), .wb_ex(wb_ex), .data_sram_req(data_sram_req),
        .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction for one cycle; the stage is expected to be empty.
    task automatic issue(input logic [7:0] op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] data, input logic we, input logic [4:0] waddr);
        ds2es_valid = 1'b1;
        ds_pc       = base ^ 32'h8000_0000;
        ds_mem_op   = op;
        ds_base     = base;
        ds_offset   = off;
        ds_st_data  = data;
        ds_rf_we    = we;
        ds_rf_waddr = waddr;
        ds_ex       = 7'h0;
        step();
        ds2es_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'b0, es2ms_valid}, 32'h0);
        check({tag, "_allowin"}, {31'b0, es_allowin}, 32'h1);
        check({tag, "_req"}, {31'b0, data_sram_req}, 32'h0);
        check({tag, "_wait"}, {31'b0, es_wait_data}, 32'h0);
    endtask

    initial begin
        resetn = 1'b0; ds2es_valid = 1'b0; ds_pc = '0; ds_base = '0; ds_offset = '0;
        ds_st_data = '0; ds_mem_op = '0; ds_rf_we = 1'b0; ds_rf_waddr = '0; ds_ex = '0;
        ms_allowin = 1'b1; ms_ex = 1'b0; wb_ex = 1'b0; data_sram_addr_ok = 1'b0;
        step();
        step();
        @(negedge clk);
        check_idle("rst");
        check("rst_es_ex", {31'b0, es_ex}, 32'h0);
        check("rst_fwd", {30'b0, es_fwd_load, es_fwd_we}, 32'h0);
        check("rst_wstrb", {28'b0, data_sram_wstrb}, 32'h0);
        check("rst_size", {30'b0, data_sram_size}, 32'h0);
        step();
        resetn = 1'b1;
        step();

        // Non-memory op passes after one cycle with the precomputed result
        issue(OP_NONE, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd5);
        @(negedge clk);
        check("alu_valid", {31'b0, es2ms_valid}, 32'h1);
        check("alu_result", es_result, 32'h1234);
        check("alu_req", {31'b0, data_sram_req}, 32'h0);
        check("alu_fwd", {26'b0, es_fwd_load, es_fwd_we, es_fwd_waddr}, {26'b0, 2'b01, 5'd5});
        step();
        @(negedge clk);
        check_idle("alu_done");

        // st_b with addr_ok arriving in the third request cycle
        issue(OP_ST_B, 32'h1000, 32'h3, 32'hAABBCCDD, 1'b0, 5'd0);
        req_cycles = 0;
        @(negedge clk);
        check("stb_addr", data_sram_addr, 32'h1003);
        check("stb_wstrb", {28'b0, data_sram_wstrb}, 32'h8);
        check("stb_wdata", data_sram_wdata, 32'hDDDDDDDD);
        check("stb_size", {30'b0, data_sram_size}, 32'h0);
        check("stb_wr", {31'b0, data_sram_wr}, 32'h1);
        check("stb_hold", {31'b0, es2ms_valid}, 32'h0);
        req_cycles += int'(data_sram_req);
        step();
        @(negedge clk);
        check("stb_addr_hold", data_sram_addr, 32'h1003);
        req_cycles += int'(data_sram_req);
        step();
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        req_cycles += int'(data_sram_req);
        check("stb_req_cycles", req_cycles, 32'd3);
        check("stb_exit", {31'b0, es2ms_valid}, 32'h1);
        check("stb_wait", {31'b0, es_wait_data}, 32'h1);
        step();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check_idle("stb_done");

        // Misaligned ld_w raises ALE and never requests
        issue(OP_LD_W, 32'h2000, 32'h2, 32'h0, 1'b1, 5'd7);
        @(negedge clk);
        check("ale_es_ex", {31'b0, es_ex}, 32'h1);
        check("ale_zip", {24'b0, es_ex_zip}, 32'h01);
        check("ale_req", {31'b0, data_sram_req}, 32'h0);
        check("ale_valid", {31'b0, es2ms_valid}, 32'h1);
        check("ale_wait", {31'b0, es_wait_data}, 32'h0);
        step();
        @(negedge clk);
        check_idle("ale_done");

        // ld_h accepted while the memory stage stalls for two cycles
        issue(OP_LD_H, 32'h3000, 32'h2, 32'h0, 1'b1, 5'd9);
        ms_allowin = 1'b0;
        data_sram_addr_ok = 1'b1;
        handshakes = 0;
        @(negedge clk);
        handshakes += int'(data_sram_req & data_sram_addr_ok);
        check("ldh_req", {31'b0, data_sram_req}, 32'h1);
        check("ldh_size", {30'b0, data_sram_size}, 32'h1);
        check("ldh_wstrb", {27'b0, data_sram_wr, data_sram_wstrb}, 32'h0);
        check("ldh_fwd_load", {31'b0, es_fwd_load}, 32'h1);
        check("ldh_ldop", {27'b0, es_ld_op}, 32'h04);
        step();
        @(negedge clk);
        handshakes += int'(data_sram_req & data_sram_addr_ok);
        check("ldh_req_low", {31'b0, data_sram_req}, 32'h0);
        check("ldh_stall_wait", {31'b0, es_wait_data}, 32'h1);
        check("ldh_allowin", {31'b0, es_allowin}, 32'h0);
        step();
        ms_allowin = 1'b1;
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        handshakes += int'(data_sram_req & data_sram_addr_ok);
        check("ldh_handshakes", handshakes, 32'd1);
        check("ldh_exit", {31'b0, es2ms_valid}, 32'h1);
        check("ldh_exit_wait", {31'b0, es_wait_data}, 32'h1);
        check("ldh_result", es_result, 32'h3002);
        step();
        @(negedge clk);
        check_idle("ldh_done");

        // st_w behind an excepting memory stage passes without a request
        ms_ex = 1'b1;
        data_sram_addr_ok = 1'b1;
        issue(OP_ST_W, 32'h4000, 32'h4, 32'h11223344, 1'b0, 5'd0);
        @(negedge clk);
        check("msex_req", {31'b0, data_sram_req}, 32'h0);
        check("msex_valid", {31'b0, es2ms_valid}, 32'h1);
        check("msex_wait", {31'b0, es_wait_data}, 32'h0);
        step();
        ms_ex = 1'b0;
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check_idle("msex_done");

        // Flush arriving together with addr_ok
        issue(OP_ST_H, 32'h5000, 32'h2, 32'h12345678, 1'b0, 5'd0);
        @(negedge clk);
        check("sth_req", {31'b0, data_sram_req}, 32'h1);
        check("sth_wstrb", {28'b0, data_sram_wstrb}, 32'hC);
        check("sth_wdata", data_sram_wdata, 32'h56785678);
        check("sth_size", {30'b0, data_sram_size}, 32'h1);
        step();
        wb_ex = 1'b1;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("flush_req", {31'b0, data_sram_req}, 32'h0);
        check("flush_wait", {31'b0, es_wait_data}, 32'h0);
        step();
        wb_ex = 1'b0;
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check_idle("flush_done");

        // Reset while a request is held
        issue(OP_ST_W, 32'h6000, 32'h0, 32'hCAFEF00D, 1'b1, 5'd3);
        @(negedge clk);
        check("rstm_req", {31'b0, data_sram_req}, 32'h1);
        check("rstm_wstrb", {28'b0, data_sram_wstrb}, 32'hF);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check_idle("rstm_done");
        check("rstm_fwd", {30'b0, es_fwd_load, es_fwd_we}, 32'h0);
        check("rstm_wstrb0", {28'b0, data_sram_wstrb}, 32'h0);
        check("rstm_size0", {30'b0, data_sram_size}, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_mem_issue.md
# exe_mem_issue

Execute-stage memory-issue block of the five-stage in-order pipeline, sitting directly upstream of the memory stage. It latches one instruction from decode, computes the effective address, detects address-misalignment (ALE), and issues load/store requests on the SRAM-like data bus (req/addr_ok). It then hands the instruction, its result and the "data_ok pending" flag to the memory stage. The memory stage waits for data_ok only when this block reports a request was accepted.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- es_allowin  out  1  stage can accept from decode
- ds2es_valid  in  1  decode offers an instruction
- ds_pc  in  32  instruction PC
- ds_base  in  32  base register value; for non-memory ops, the precomputed result
- ds_offset  in  32  sign-extended offset
- ds_st_data  in  32  store source register
- ds_mem_op  in  8  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w}; all zero means non-memory op
- ds_rf_we, ds_rf_waddr  in  1, 5  destination write enable and address
- ds_ex  in  7  exception flags already raised upstream
- ms_allowin  in  1  memory stage can accept
- es2ms_valid  out  1  instruction offered to memory stage
- es_pc  out  32  latched PC
- es_result  out  32  address for memory ops, else latched ds_base
- es_ld_op  out  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}
- es_wait_data  out  1  a request for this instruction was accepted
- es_ex_zip  out  8  {ds_ex, ale}
- es_fwd_load, es_fwd_we  out  1, 1  forwarding/blocking info; each gated by the stage valid bit
- es_fwd_waddr  out  5  forwarding destination address
- es_ex  out  1  stage holds a valid excepting instruction
- ms_ex, wb_ex  in  1, 1  exception in memory stage / writeback flush
- data_sram_req, data_sram_wr  out  1, 1  request valid / write
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_wstrb  out  4  byte strobes, zero for loads
- data_sram_addr, data_sram_wdata  out  32, 32  request address and replicated store data
- data_sram_addr_ok  in  1  request accepted this cycle

## Operation
- Registers: es_valid, req_sent, and all latched ds_* fields. The ds_* fields load when ds2es_valid & es_allowin.
- es_valid priority:
  - reset → 0
  - else wb_ex → 0
  - else es_allowin → ds2es_valid
- addr = base + offset (mod 2^32).
- Misalignment:
  - ale = (ld_h|ld_hu|st_h) & addr[0], or (ld_w|st_w) & (addr[1:0]≠0).
  - es_ex = es_valid & (|ds_ex | ale).
- Request: data_sram_req = es_valid & is_mem & ~es_ex & ~ms_ex & ~wb_ex & ~req_sent.
  - A request never issues behind an excepting memory stage or during a flush; an excepting instruction never issues one.
- Store formatting:
  - st_b: wstrb = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}
  - st_h: wstrb = 4'b0011 << {addr[1],1'b0}, wdata = {2{d[15:0]}}
  - st_w: wstrb = 4'hF, wdata = d
  - Loads: wstrb = 0 and wr = 0.
- req_sent priority:
  - set on req & addr_ok when the instruction does not leave this cycle
  - cleared when the instruction leaves (es2ms_valid & ms_allowin)
  - cleared by reset or wb_ex
- es_wait_data = req_sent | (req & addr_ok).

## Timing
- need_req = is_mem & ~es_ex & ~ms_ex.
- es_ready_go = ~need_req | req_sent | (req & addr_ok).
  - Excepting memory ops, and memory ops behind ms_ex, pass without a request.
- es_allowin = ~es_valid | (es_ready_go & ms_allowin).
- es2ms_valid = es_valid & es_ready_go.
- Latency:
  - Non-memory op: 1 cycle in the stage.
  - Memory op: leaves in the same cycle addr_ok is seen if ms_allowin; otherwise it holds with req low (req_sent = 1).
- Request hold: req stays asserted with addr/size/wstrb/wdata stable until addr_ok. Addr_ok while req is low is ignored.
- wb_ex in the same cycle as addr_ok: req is forced low, so no handshake occurs. es_valid and req_sent are 0 next cycle.
- Reset values: es_valid = 0, req_sent = 0. Hence data_sram_req, es2ms_valid, es_ex, es_wait_data and the fwd enables are all 0, and es_allowin = 1.
- Data outputs (addr, wdata, result) are don't-care while es_valid = 0. wstrb and size are driven from latched op fields reset to 0.

## Test plan
- **Non-memory op:** ld disabled, base = 0x1234, ms_allowin = 1 → es2ms_valid on the cycle after capture; es_result = 0x1234; req never asserted.
- **st_b:** base = 0x1000, offset = 3, data = 0xAABBCCDD, addr_ok delayed 2 cycles → req held 3 cycles; addr = 0x1003, wstrb = 4'b1000, wdata = 0xDDDDDDDD, size = 0; es_wait_data = 1 on exit.
- **Misaligned ld_w:** addr = 0x2002 → ale = 1, es_ex = 1, no req, passes in 1 cycle; es_ex_zip[0] = 1, es_wait_data = 0.
- **Accept then stall:** ld_h at 0x3002, addr_ok while ms_allowin = 0 for 2 cycles → exactly one handshake; req low afterwards; es_wait_data = 1 on exit.
- **Exception interlock:** ms_ex = 1 with st_w pending → no req; the store passes with es_wait_data = 0.
- **Flush during request:** wb_ex asserted in the same cycle as addr_ok → req low that cycle; next cycle es_valid = 0, es_allowin = 1.
- **Reset mid-request:** resetn = 0 while req is held → all outputs return to reset values the next cycle.
